// File: rtl/pe_pkg.sv
// pe_pkg: constants, drain-state encoding and lane arithmetic shared by the
// PE core stages (result writeback, MAC array).
package pe_pkg;

  // Bytes moved by one 256-bit write beat; the write address advances by this.
  localparam int BEAT_BYTES = 32;

  // Lane format used by the saturating arithmetic: signed two's complement.
  localparam int LANE_W = 16;

  typedef enum logic {
    IDLE,
    REQ
  } drain_state_e;

  typedef struct packed {
    logic [LANE_W-1:0] sum;
    logic              clipped;
  } lane_sum_t;

  // Signed add one bit wider than a lane, clipped to the lane's max/min.
  // Overflow shows as disagreement between the two top bits of the wide sum.
  function automatic lane_sum_t sat_add(input logic [LANE_W-1:0] a,
                                        input logic [LANE_W-1:0] b);
    logic [LANE_W:0] wide;
    lane_sum_t       r;
    wide      = {a[LANE_W-1], a} + {b[LANE_W-1], b};
    r.clipped = wide[LANE_W] ^ wide[LANE_W-1];
    if (!r.clipped) begin
      r.sum = wide[LANE_W-1:0];
    end else if (wide[LANE_W]) begin
      r.sum = {1'b1, {(LANE_W-1){1'b0}}};
    end else begin
      r.sum = {1'b0, {(LANE_W-1){1'b1}}};
    end
    return r;
  endfunction

endpackage

// File: rtl/pe_sync_fifo.sv
// pe_sync_fifo: synchronous FIFO with registered full/empty and an occupancy
// count. A push and a pop in the same cycle are both honoured; a push while
// full is dropped, so the producer must gate on full_o.
module pe_sync_fifo #(
  parameter int WIDTH = 256,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push_i,
  input  logic [WIDTH-1:0]       push_data_i,
  input  logic                   pop_i,
  output logic [WIDTH-1:0]       head_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;
  logic [WIDTH-1:0] mem_q [DEPTH];

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  // Next pointers and occupancy; pointers wrap naturally since DEPTH is 2^AW.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    count_d = count_q + CW'(do_push) - CW'(do_pop);
  end

  // Pointer and count registers.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage.
  always_ff @(posedge clk) begin
    // NOTE: storage is deliberately not reset; the count marks which entries
    // are valid, and consumers gate the head when empty.
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/pe_result_writeback.sv
// pe_result_writeback: accumulates PE result beats lane-wise with signed
// saturation, buffers completed vectors, and drains them as 256-bit write
// requests over a req/ack handshake with address sequencing and counters.
module pe_result_writeback
  import pe_pkg::*;
#(
  parameter int DATA_WIDTH   = LANE_W,
  parameter int VECTOR_WIDTH = 16,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               in_valid,
  output logic                               in_ready,
  input  logic [DATA_WIDTH*VECTOR_WIDTH-1:0] in_data,
  input  logic                               in_accum,
  input  logic                               in_last,
  input  logic                               cfg_load,
  input  logic [31:0]                        base_addr_i,
  output logic                               mem_req_o,
  output logic [31:0]                        mem_addr_o,
  output logic [DATA_WIDTH*VECTOR_WIDTH-1:0] mem_data_o,
  input  logic                               mem_ack_i,
  output logic                               busy_o,
  output logic [15:0]                        wr_count_o,
  output logic                               overflow_o
);

  localparam int VEC_W = DATA_WIDTH * VECTOR_WIDTH;
  localparam int CW    = $clog2(FIFO_DEPTH) + 1;

  drain_state_e state_q, state_d;

  logic [VEC_W-1:0] acc_q, acc_d;
  logic             group_open_q, group_open_d;
  logic [31:0]      addr_q, addr_d;
  logic [15:0]      wr_count_q, wr_count_d;
  logic             overflow_q, overflow_d;

  logic [VEC_W-1:0] sum_vec;
  logic             any_clip;
  logic             use_acc;
  logic             beat_accept;
  logic             cfg_ok;
  logic             mem_pop;
  logic [CW-1:0]    occ_after;

  logic             fifo_push;
  logic             fifo_full, fifo_empty;
  logic [VEC_W-1:0] fifo_head;
  logic [CW-1:0]    fifo_count;

  // Ready comes from the registered full flag, so a slot freed by a pop this
  // cycle is only offered next cycle. Held low while reset is asserted.
  assign in_ready    = ~fifo_full & ~rst;
  assign beat_accept = in_valid & in_ready;
  assign fifo_push   = beat_accept & in_last;
  assign use_acc     = in_accum & group_open_q;
  assign cfg_ok      = cfg_load & (state_q == IDLE) & fifo_empty & ~group_open_q;

  assign mem_req_o   = (state_q == REQ);
  assign mem_addr_o  = addr_q;
  assign mem_data_o  = fifo_empty ? '0 : fifo_head;
  assign busy_o      = ~fifo_empty | (state_q == REQ) | group_open_q;
  assign wr_count_o  = wr_count_q;
  assign overflow_o  = overflow_q;

  pe_sync_fifo #(
    .WIDTH (VEC_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (fifo_push),
    .push_data_i (sum_vec),
    .pop_i       (mem_pop),
    .head_o      (fifo_head),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .count_o     (fifo_count)
  );

  // Lane-wise sum: pass the beat through unless it continues an open group.
  always_comb begin
    sum_vec  = in_data;
    any_clip = 1'b0;
    for (int i = 0; i < VECTOR_WIDTH; i++) begin
      lane_sum_t lane_r;
      lane_r = sat_add(acc_q[i*DATA_WIDTH +: DATA_WIDTH],
                       in_data[i*DATA_WIDTH +: DATA_WIDTH]);
      if (use_acc) begin
        sum_vec[i*DATA_WIDTH +: DATA_WIDTH] = lane_r.sum;
        any_clip = any_clip | lane_r.clipped;
      end
    end
  end

  // Accumulator next state: a last beat closes the group and clears acc.
  always_comb begin
    acc_d        = acc_q;
    group_open_d = group_open_q;
    if (beat_accept) begin
      if (in_last) begin
        acc_d        = '0;
        group_open_d = 1'b0;
      end else begin
        acc_d        = sum_vec;
        group_open_d = 1'b1;
      end
    end
  end

  // Accumulator registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q        <= '0;
      group_open_q <= 1'b0;
    end else begin
      acc_q        <= acc_d;
      group_open_q <= group_open_d;
    end
  end

  // Drain FSM: request while the FIFO holds data; stay in REQ across
  // back-to-back acks as long as something remains after the pop.
  always_comb begin
    state_d   = state_q;
    mem_pop   = 1'b0;
    occ_after = fifo_count;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) state_d = REQ;
      end
      REQ: begin
        if (mem_ack_i) begin
          mem_pop   = 1'b1;
          occ_after = fifo_count + CW'(fifo_push) - CW'(1'b1);
          if (occ_after == '0) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Drain state register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Address, write count and sticky overflow; cfg_load only when quiescent.
  always_comb begin
    addr_d     = addr_q;
    wr_count_d = wr_count_q;
    overflow_d = overflow_q;
    if (cfg_ok) begin
      addr_d     = base_addr_i;
      wr_count_d = '0;
      overflow_d = 1'b0;
    end else begin
      if (mem_pop) begin
        addr_d     = addr_q + 32'(BEAT_BYTES);
        wr_count_d = wr_count_q + 16'd1;
      end
      if (beat_accept && any_clip) overflow_d = 1'b1;
    end
  end

  // Counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q     <= '0;
      wr_count_q <= '0;
      overflow_q <= 1'b0;
    end else begin
      addr_q     <= addr_d;
      wr_count_q <= wr_count_d;
      overflow_q <= overflow_d;
    end
  end

endmodule

// File: tb/tb_pe_result_writeback.sv
// tb_pe_result_writeback: directed test of the result writeback stage with a
// scoreboard of expected write data and an address model.
module tb_pe_result_writeback;

  localparam int VW  = 16;
  localparam int VEC = 256;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            in_valid = 1'b0;
  logic            in_accum = 1'b0;
  logic            in_last = 1'b0;
  logic            cfg_load = 1'b0;
  logic            mem_ack_i = 1'b0;
  logic [VEC-1:0]  in_data = '0;
  logic [31:0]     base_addr_i = '0;
  logic            in_ready, mem_req_o, busy_o, overflow_o;
  logic [VEC-1:0]  mem_data_o;
  logic [31:0]     mem_addr_o;
  logic [15:0]     wr_count_o;

  int              checks = 0;
  int              errors = 0;
  int              wr_seen = 0;
  int              load_mark = 0;
  logic [31:0]     exp_base = '0;
  logic [VEC-1:0]  sb [$];
  logic [VEC-1:0]  mon_exp;
  logic [31:0]     mon_addr;

  pe_result_writeback dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .in_accum    (in_accum),
    .in_last     (in_last),
    .cfg_load    (cfg_load),
    .base_addr_i (base_addr_i),
    .mem_req_o   (mem_req_o),
    .mem_addr_o  (mem_addr_o),
    .mem_data_o  (mem_data_o),
    .mem_ack_i   (mem_ack_i),
    .busy_o      (busy_o),
    .wr_count_o  (wr_count_o),
    .overflow_o  (overflow_o)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not reach its end");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [VEC-1:0] obs, input logic [VEC-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [VEC-1:0] splat(input logic [15:0] v);
    return {VW{v}};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Write monitor: each accepted write pops the scoreboard and is checked
  // against the expected data and the modelled address.
  always @(negedge clk) begin
    if (!rst && mem_req_o && mem_ack_i) begin
      mon_addr = exp_base + 32'(32 * (wr_seen - load_mark));
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $error("FAIL unexpected_write: observed write to %0h expected none", mem_addr_o);
      end else begin
        mon_exp = sb.pop_front();
        check("wr_data", mem_data_o, mon_exp);
        check("wr_addr", VEC'(mem_addr_o), VEC'(mon_addr));
      end
      wr_seen++;
    end
  end

  // Called at posedge+1; returns at posedge+1 right after the accepting edge.
  task automatic send_beat(input logic [VEC-1:0] d, input logic acc, input logic last,
                           input logic [VEC-1:0] exp);
    int n = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_accum = acc;
    in_last  = last;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("beat_ready", VEC'(in_ready), VEC'(1'b1));
    step();
    in_valid = 1'b0;
    in_accum = 1'b0;
    in_last  = 1'b0;
    if (last) sb.push_back(exp);
  endtask

  task automatic do_cfg(input logic [31:0] base);
    cfg_load    = 1'b1;
    base_addr_i = base;
    step();
    cfg_load    = 1'b0;
  endtask

  task automatic wait_writes(input int target);
    int n = 0;
    mem_ack_i = 1'b1;
    while (wr_seen < target && n < 200) begin
      @(negedge clk);
      n++;
    end
    step();
    mem_ack_i = 1'b0;
    check("writes_reached", VEC'(wr_seen), VEC'(target));
  endtask

  logic [VEC-1:0] t1_data;
  logic [VEC-1:0] sat_a, sat_exp;
  int             wr_base;

  initial begin
    for (int i = 0; i < VW; i++) t1_data[i*16 +: 16] = 16'(i + 1);
    sat_a          = splat(16'h0001);
    sat_a[15:0]    = 16'h7000;
    sat_a[31:16]   = 16'h9000;
    sat_exp        = splat(16'h0002);
    sat_exp[15:0]  = 16'h7FFF;
    sat_exp[31:16] = 16'h8000;

    // Reset state.
    step();
    step();
    @(negedge clk);
    check("rst_in_ready", VEC'(in_ready), VEC'(1'b0));
    check("rst_req", VEC'(mem_req_o), VEC'(1'b0));
    check("rst_addr", VEC'(mem_addr_o), VEC'(32'h0));
    check("rst_data", mem_data_o, '0);
    check("rst_wr_count", VEC'(wr_count_o), VEC'(16'h0));
    check("rst_overflow", VEC'(overflow_o), VEC'(1'b0));
    check("rst_busy", VEC'(busy_o), VEC'(1'b0));
    step();
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_ready", VEC'(in_ready), VEC'(1'b1));
    step();

    // Single beat with delayed ack.
    do_cfg(32'h0000_1000);
    exp_base  = 32'h0000_1000;
    load_mark = wr_seen;
    send_beat(t1_data, 1'b0, 1'b1, t1_data);
    @(negedge clk);
    check("lat_req_low_n1", VEC'(mem_req_o), VEC'(1'b0));
    check("lat_busy_n1", VEC'(busy_o), VEC'(1'b1));
    step();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("hold_req", VEC'(mem_req_o), VEC'(1'b1));
      check("hold_addr", VEC'(mem_addr_o), VEC'(32'h0000_1000));
      check("hold_data", mem_data_o, t1_data);
      step();
    end
    mem_ack_i = 1'b1;
    step();
    mem_ack_i = 1'b0;
    @(negedge clk);
    check("single_req_after", VEC'(mem_req_o), VEC'(1'b0));
    check("single_wr_count", VEC'(wr_count_o), VEC'(16'd1));
    check("single_busy_after", VEC'(busy_o), VEC'(1'b0));
    step();

    // Accumulate three beats into one write.
    send_beat(splat(16'h0100), 1'b0, 1'b0, '0);
    send_beat(splat(16'h0100), 1'b1, 1'b0, '0);
    send_beat(splat(16'h0100), 1'b1, 1'b1, splat(16'h0300));
    wait_writes(wr_seen + 1);
    @(negedge clk);
    check("accum_wr_count", VEC'(wr_count_o), VEC'(16'd2));
    check("accum_overflow", VEC'(overflow_o), VEC'(1'b0));
    step();

    // Saturation in both directions; overflow is sticky.
    send_beat(sat_a, 1'b0, 1'b0, '0);
    @(negedge clk);
    check("sat_no_ovf_yet", VEC'(overflow_o), VEC'(1'b0));
    step();
    send_beat(sat_a, 1'b1, 1'b1, sat_exp);
    @(negedge clk);
    check("sat_ovf_set", VEC'(overflow_o), VEC'(1'b1));
    step();
    wait_writes(wr_seen + 1);
    @(negedge clk);
    check("sat_ovf_sticky", VEC'(overflow_o), VEC'(1'b1));
    step();

    // Backpressure: four beats fill the FIFO, the fifth waits for an ack.
    do_cfg(32'h0000_1000);
    exp_base  = 32'h0000_1000;
    load_mark = wr_seen;
    wr_base   = wr_seen;
    @(negedge clk);
    check("cfg_clears_ovf", VEC'(overflow_o), VEC'(1'b0));
    check("cfg_clears_count", VEC'(wr_count_o), VEC'(16'd0));
    step();
    for (int k = 1; k <= 4; k++) send_beat(splat(16'(k * 16'h0101)), 1'b0, 1'b1, splat(16'(k * 16'h0101)));
    in_valid = 1'b1;
    in_data  = splat(16'h0505);
    in_last  = 1'b1;
    @(negedge clk);
    check("bp_ready_full", VEC'(in_ready), VEC'(1'b0));
    step();
    mem_ack_i = 1'b1;
    @(negedge clk);
    check("bp_ready_ack_cycle", VEC'(in_ready), VEC'(1'b0));
    step();
    @(negedge clk);
    check("bp_ready_after_ack", VEC'(in_ready), VEC'(1'b1));
    step();
    in_valid = 1'b0;
    in_last  = 1'b0;
    sb.push_back(splat(16'h0505));
    wait_writes(wr_base + 5);
    @(negedge clk);
    check("bp_wr_count", VEC'(wr_count_o), VEC'(16'd5));
    step();

    // cfg_load while requesting is ignored.
    do_cfg(32'h0000_1000);
    exp_base  = 32'h0000_1000;
    load_mark = wr_seen;
    send_beat(splat(16'h0011), 1'b0, 1'b1, splat(16'h0011));
    send_beat(splat(16'h0022), 1'b0, 1'b1, splat(16'h0022));
    @(negedge clk);
    check("ign_req_high", VEC'(mem_req_o), VEC'(1'b1));
    step();
    do_cfg(32'h0000_2000);
    @(negedge clk);
    check("ign_addr_kept", VEC'(mem_addr_o), VEC'(32'h0000_1000));
    step();
    wait_writes(wr_seen + 2);
    @(negedge clk);
    check("ign_wr_count", VEC'(wr_count_o), VEC'(16'd2));
    step();

    // Address wrap at the top of the 32-bit space.
    do_cfg(32'hFFFF_FFE0);
    exp_base  = 32'hFFFF_FFE0;
    load_mark = wr_seen;
    send_beat(splat(16'h00AA), 1'b0, 1'b1, splat(16'h00AA));
    send_beat(splat(16'h00BB), 1'b0, 1'b1, splat(16'h00BB));
    wait_writes(wr_seen + 2);
    @(negedge clk);
    check("wrap_addr_after", VEC'(mem_addr_o), VEC'(32'h0000_0020));
    step();

    // Reset mid-request with two queued entries and an open group.
    send_beat(splat(16'h0033), 1'b0, 1'b1, splat(16'h0033));
    send_beat(splat(16'h0044), 1'b0, 1'b1, splat(16'h0044));
    send_beat(splat(16'h0055), 1'b0, 1'b0, '0);
    @(negedge clk);
    check("mid_req_high", VEC'(mem_req_o), VEC'(1'b1));
    step();
    rst = 1'b1;
    sb.delete();
    step();
    @(negedge clk);
    check("mid_rst_req", VEC'(mem_req_o), VEC'(1'b0));
    check("mid_rst_addr", VEC'(mem_addr_o), VEC'(32'h0));
    check("mid_rst_data", mem_data_o, '0);
    check("mid_rst_count", VEC'(wr_count_o), VEC'(16'h0));
    check("mid_rst_busy", VEC'(busy_o), VEC'(1'b0));
    check("mid_rst_ready", VEC'(in_ready), VEC'(1'b0));
    step();
    rst       = 1'b0;
    exp_base  = 32'h0;
    load_mark = wr_seen;
    send_beat(splat(16'h0005), 1'b1, 1'b1, splat(16'h0005));
    wait_writes(wr_seen + 1);
    @(negedge clk);
    check("post_rst_wr_count", VEC'(wr_count_o), VEC'(16'd1));
    check("scoreboard_empty", VEC'(sb.size()), '0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
